// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI frame controller: state encoding, default frame
// geometry and the bit-counter width helper.
package spi_ctrl_pkg;

  localparam int unsigned DefAddrBits = 7;
  localparam int unsigned DefDataBits = 8;

  typedef logic [2:0] state_t;

  localparam state_t StIdle        = 3'd0;
  localparam state_t StGetAddr     = 3'd1;
  localparam state_t StGotAddr     = 3'd2;
  localparam state_t StReadLoad    = 3'd3;
  localparam state_t StReadShift   = 3'd4;
  localparam state_t StWriteShift  = 3'd5;
  localparam state_t StWriteCommit = 3'd6;
  localparam state_t StDone        = 3'd7;

  // Wide enough to hold the larger of the two terminal counts.
  function automatic int unsigned cnt_width(input int unsigned addr_bits,
                                            input int unsigned data_bits);
    int unsigned max_cnt;
    max_cnt = (addr_bits + 1 > data_bits) ? addr_bits + 1 : data_bits;
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Edge counter with synchronous clear and a terminal flag that fires on the pulse
// that brings the count up to a runtime-selected target.
module spi_bit_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [Width-1:0] target,
  output logic             last
);

  logic [Width-1:0] count_q, count_d;

  // Flags the current pulse, so the FSM can leave in the same cycle it arrives.
  assign last = inc && ((count_q + Width'(1)) == target);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_frame_controller.sv
// Sequences one SPI frame: address capture, R/W decision, read load/shift or write
// shift/commit. Define SPI_CTRL_TXN_COUNT_EN to add the completed-frame counter.
module spi_frame_controller
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DefAddrBits,
  parameter int unsigned DATA_BITS = DefDataBits
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipSelect,
  input  logic        sclkPosEdge,
  input  logic        sclkNegEdge,
  input  logic        readWrite,
  output logic        srLoad,
  output logic        addrLatchEn,
  output logic        dmWe,
  output logic        misoBufEn
`ifdef SPI_CTRL_TXN_COUNT_EN
  ,
  output logic [15:0] txnCount
`endif
);

  localparam int unsigned CntW = cnt_width(ADDR_BITS, DATA_BITS);
  localparam logic [CntW-1:0] AddrTarget = CntW'(ADDR_BITS + 1);
  localparam logic [CntW-1:0] DataTarget = CntW'(DATA_BITS);

  state_t          state_q, state_d;
  logic            cnt_inc, cnt_clear, cnt_last;
  logic [CntW-1:0] cnt_target;

  // Counting is split from next-state so the terminal flag never loops back on itself.
  always_comb begin
    cnt_inc    = 1'b0;
    cnt_target = DataTarget;
    if (!chipSelect) begin
      case (state_q)
        StGetAddr: begin
          cnt_inc    = sclkPosEdge;
          cnt_target = AddrTarget;
        end
        StReadShift:  cnt_inc = sclkNegEdge;
        StWriteShift: cnt_inc = sclkPosEdge;
        default:      cnt_inc = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:        state_d = StGetAddr;
      StGetAddr:     if (cnt_last) state_d = StGotAddr;
      StGotAddr:     state_d = readWrite ? StReadLoad : StWriteShift;
      StReadLoad:    state_d = StReadShift;
      StReadShift:   if (cnt_last) state_d = StDone;
      StWriteShift:  if (cnt_last) state_d = StWriteCommit;
      StWriteCommit: state_d = StDone;
      StDone:        state_d = StDone;
      default:       state_d = StIdle;
    endcase
    // Deselect wins over any edge pulse in the same cycle.
    if (chipSelect) begin
      state_d = StIdle;
    end
  end

  assign cnt_clear = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  spi_bit_counter #(
    .Width (CntW)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .target (cnt_target),
    .last   (cnt_last)
  );

  assign addrLatchEn = (state_q == StGotAddr);
  assign srLoad      = (state_q == StReadLoad);
  assign misoBufEn   = (state_q == StReadShift);
  assign dmWe        = (state_q == StWriteCommit);

`ifdef SPI_CTRL_TXN_COUNT_EN
  logic [15:0] txn_count_q, txn_count_d;

  // Aborts force IDLE in state_d, so they never look like an entry to DONE.
  always_comb begin
    txn_count_d = txn_count_q;
    if ((state_d == StDone) && (state_q != StDone)) begin
      txn_count_d = txn_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txn_count_q <= 16'd0;
    end else begin
      txn_count_q <= txn_count_d;
    end
  end

  assign txnCount = txn_count_q;
`endif

endmodule

// File: tb/tb_spi_frame_controller.sv
// Scoreboard bench for spi_frame_controller: each scenario builds a per-cycle stimulus
// list with expected strobes, then replays it and compares every cycle.
module tb_spi_frame_controller;

  localparam logic [3:0] VSr   = 4'b0001;
  localparam logic [3:0] VAle  = 4'b0010;
  localparam logic [3:0] VWe   = 4'b0100;
  localparam logic [3:0] VMiso = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, chipSelect, sclkPosEdge, sclkNegEdge, readWrite;
  logic srLoad, addrLatchEn, dmWe, misoBufEn;
`ifdef SPI_CTRL_TXN_COUNT_EN
  logic [15:0] txnCount;
`endif

  spi_frame_controller dut (
    .clk         (clk),
    .reset       (reset),
    .chipSelect  (chipSelect),
    .sclkPosEdge (sclkPosEdge),
    .sclkNegEdge (sclkNegEdge),
    .readWrite   (readWrite),
    .srLoad      (srLoad),
    .addrLatchEn (addrLatchEn),
    .dmWe        (dmWe),
    .misoBufEn   (misoBufEn)
`ifdef SPI_CTRL_TXN_COUNT_EN
    ,
    .txnCount    (txnCount)
`endif
  );

  typedef struct packed {
    logic rst;
    logic cs;
    logic pos;
    logic neg;
    logic rw;
  } stim_t;

  stim_t       stim_q[$];
  logic [3:0]  exp_q[$];   // expected {misoBufEn, dmWe, addrLatchEn, srLoad} per cycle
  int          last_pos = 0;
  int          last_neg = 0;
  logic        cur_rw = 1'b0;
  logic [15:0] exp_txn = 16'd0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  task automatic add(input logic rst, input logic cs, input logic pos, input logic neg);
    stim_t s;
    s.rst = rst;
    s.cs  = cs;
    s.pos = pos;
    s.neg = neg;
    s.rw  = cur_rw;
    if (pos) last_pos = stim_q.size();
    if (neg) last_neg = stim_q.size();
    stim_q.push_back(s);
    exp_q.push_back(4'b0000);
  endtask

  // One SCLK period of 4 clk, MSB first; the shift register's bit 0 follows the pos pulse.
  task automatic add_bits(input logic [15:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      add(1'b0, 1'b0, 1'b1, 1'b0);
      cur_rw = v[k];
      add(1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic mark(input int idx, input logic [3:0] bits);
    exp_q[idx] = exp_q[idx] | bits;
  endtask

  // Full frame from IDLE; "extra" SCLK periods are clocked while sitting in DONE.
  task automatic add_frame(input logic [6:0] a, input logic rw, input logic [7:0] d,
                           input int extra);
    int j;
    add(1'b0, 1'b0, 1'b0, 1'b0);
    add_bits({8'h00, a, rw}, 8);
    j = last_pos;
    mark(j, VAle);
    add_bits({8'h00, d}, 8);
    if (rw) begin
      mark(j + 1, VSr);
      for (int k = j + 2; k < last_neg; k++) mark(k, VMiso);
    end else begin
      mark(last_pos, VWe);
    end
    if (extra > 0) add_bits(16'hFFFF, extra);
    add(1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0);
    exp_txn = exp_txn + 16'd1;
  endtask

  task automatic apply(input stim_t s, output logic [3:0] o);
    @(negedge clk);
    reset       = s.rst;
    chipSelect  = s.cs;
    sclkPosEdge = s.pos;
    sclkNegEdge = s.neg;
    readWrite   = s.rw;
    @(posedge clk);
    #1;
    o = {misoBufEn, dmWe, addrLatchEn, srLoad};
    cyc++;
  endtask

  task automatic test_reset;
    stim_t s;
    logic [3:0] o, e;
    add(1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0);
    exp_txn = 16'd0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      apply(s, o);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset cyc=%0d outs=%b expected=%b", cyc, o, e);
      end
    end
`ifdef SPI_CTRL_TXN_COUNT_EN
    total++;
    if (txnCount !== 16'd0) begin
      bad++;
      $display("FAIL reset_txn got=%h expected=0000", txnCount);
    end
`endif
  endtask

  task automatic test_reset_mid_write;
    stim_t s;
    logic [3:0] o, e;
    add(1'b0, 1'b0, 1'b0, 1'b0);
    add_bits({8'h00, 7'h2A, 1'b0}, 8);
    mark(last_pos, VAle);
    add_bits(16'h0014, 5);           // top five bits of 0xA5
    add(1'b1, 1'b0, 1'b0, 1'b0);
    add_bits(16'h0005, 3);
    add(1'b0, 1'b1, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      apply(s, o);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_mid_write cyc=%0d outs=%b expected=%b", cyc, o, e);
      end
    end
`ifdef SPI_CTRL_TXN_COUNT_EN
    total++;
    if (txnCount !== exp_txn) begin
      bad++;
      $display("FAIL reset_mid_write_txn got=%h expected=%h", txnCount, exp_txn);
    end
`endif
  endtask

  task automatic test_write;
    stim_t s;
    logic [3:0] o, e;
    add_frame(7'h2A, 1'b0, 8'hA5, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      apply(s, o);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL write cyc=%0d outs=%b expected=%b", cyc, o, e);
      end
    end
  endtask

  task automatic test_read;
    stim_t s;
    logic [3:0] o, e;
    add_frame(7'h15, 1'b1, 8'h3C, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      apply(s, o);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL read cyc=%0d outs=%b expected=%b", cyc, o, e);
      end
    end
  endtask

  task automatic test_abort;
    stim_t s;
    logic [3:0] o, e;
    // Deselect after four address bits.
    add(1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(16'h0005, 4);
    add(1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0);
    // Deselect in the same cycle as the final address pulse: no address latch.
    add(1'b0, 1'b0, 1'b0, 1'b0);
    add_bits(16'h0015, 7);
    add(1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0);
    // Deselect on the final data pulse of a write: no commit.
    add(1'b0, 1'b0, 1'b0, 1'b0);
    add_bits({8'h00, 7'h2A, 1'b0}, 8);
    mark(last_pos, VAle);
    add_bits(16'h0052, 7);
    add(1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0);
    add_frame(7'h33, 1'b0, 8'h0F, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      apply(s, o);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL abort cyc=%0d outs=%b expected=%b", cyc, o, e);
      end
    end
  endtask

  task automatic test_done_extra;
    stim_t s;
    logic [3:0] o, e;
    add_frame(7'h7F, 1'b0, 8'hFF, 6);
    add_frame(7'h00, 1'b1, 8'h00, 3);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      apply(s, o);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL done_extra cyc=%0d outs=%b expected=%b", cyc, o, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    stim_t s;
    logic [3:0] o, e;
    add(1'b1, 1'b1, 1'b0, 1'b0);
    exp_txn = 16'd0;
    add_frame(7'h01, 1'b0, 8'h80, 0);
    add_frame(7'h40, 1'b1, 8'h01, 0);
    add_frame(7'h55, 1'b0, 8'h5A, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      apply(s, o);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d outs=%b expected=%b", cyc, o, e);
      end
    end
`ifdef SPI_CTRL_TXN_COUNT_EN
    total++;
    if (txnCount !== exp_txn) begin
      bad++;
      $display("FAIL back_to_back_txn got=%h expected=%h", txnCount, exp_txn);
    end
`endif
  endtask

`ifdef SPI_CTRL_TXN_COUNT_EN
  task automatic test_txn_wrap;
    stim_t s;
    logic [3:0] o, e;
    force dut.txn_count_q = 16'hFFFF;
    s.rst = 1'b0;
    s.cs  = 1'b1;
    s.pos = 1'b0;
    s.neg = 1'b0;
    s.rw  = 1'b0;
    apply(s, o);
    release dut.txn_count_q;
    total++;
    if (o !== 4'b0000) begin
      bad++;
      $display("FAIL txn_wrap_idle outs=%b expected=0000", o);
    end
    exp_txn = 16'hFFFF;
    add_frame(7'h2A, 1'b0, 8'hC3, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      apply(s, o);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL txn_wrap cyc=%0d outs=%b expected=%b", cyc, o, e);
      end
    end
    total++;
    if (txnCount !== exp_txn) begin
      bad++;
      $display("FAIL txn_wrap_count got=%h expected=%h", txnCount, exp_txn);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    chipSelect  = 1'b1;
    sclkPosEdge = 1'b0;
    sclkNegEdge = 1'b0;
    readWrite   = 1'b0;
    test_reset();
    test_reset_mid_write();
    test_write();
    test_read();
    test_abort();
    test_done_extra();
    test_back_to_back();
`ifdef SPI_CTRL_TXN_COUNT_EN
    test_txn_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_controller.md
# spi_frame_controller

Finite-state controller that sequences one SPI peripheral frame around the shift-register datapath. It counts conditioned serial-clock edges, latches the address, decides read or write from the R/W bit, and drives the shift-register parallel load, address latch, data-memory write enable and MISO buffer enable. It sits between the SPI input conditioners (chip select, SCLK edge detect) and the shift register / address latch / data memory.

## Interface
- ADDR_BITS, default 7: address bits per frame, received MSB first.
- DATA_BITS, default 8: data bits per frame.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- chipSelect  input  1  conditioned CS, active low.
- sclkPosEdge  input  1  one-clk pulse per conditioned SCLK rising edge; the shift register shifts on this same pulse.
- sclkNegEdge  input  1  one-clk pulse per conditioned SCLK falling edge.
- readWrite  input  1  shift register bit [0] (most recently received bit); 1 = read, 0 = write.
- srLoad  output  1  shift register parallel-load strobe.
- addrLatchEn  output  1  address latch enable.
- dmWe  output  1  data-memory write enable.
- misoBufEn  output  1  MISO tristate-buffer enable.
- txnCount  output  16  completed-transaction count (present only with SPI_CTRL_TXN_COUNT_EN).

## Operation
- States: IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT, DONE.
- Bit counter, width clog2(max(ADDR_BITS+1, DATA_BITS)+1), cleared on every state change.
- IDLE: chipSelect low -> GET_ADDR. SCLK pulses in the same cycle are not counted.
- GET_ADDR: count sclkPosEdge; on the clk edge that samples pulse ADDR_BITS+1 -> GOT_ADDR.
- GOT_ADDR (one cycle): addrLatchEn=1; sample readWrite; 1 -> READ_LOAD, 0 -> WRITE_SHIFT.
- READ_LOAD (one cycle): srLoad=1 (memory read is combinational from the latched address) -> READ_SHIFT.
- READ_SHIFT: misoBufEn=1; count sclkNegEdge; on pulse DATA_BITS -> DONE.
- WRITE_SHIFT: count sclkPosEdge; on pulse DATA_BITS -> WRITE_COMMIT.
- WRITE_COMMIT (one cycle): dmWe=1 -> DONE.
- DONE: all outputs low; SCLK pulses are ignored; wait for chipSelect high.
- Abort: chipSelect high in any state -> IDLE on the next edge. The abort overrides any same-cycle edge pulse. No srLoad, addrLatchEn or dmWe is issued in the abort cycle.
- All outputs are registered-state decodes (Moore). No output depends combinationally on inputs.

## Timing
- Reset: state IDLE, counter 0, srLoad=addrLatchEn=dmWe=misoBufEn=0, txnCount=0. Reset takes priority over everything, including mid-frame; a reset during WRITE_SHIFT means no dmWe is issued.
- addrLatchEn is high in the clk cycle immediately after the cycle carrying the (ADDR_BITS+1)th sclkPosEdge.
- srLoad is high exactly 2 cycles after that pulse. misoBufEn rises 3 cycles after it and stays high until the cycle after the DATA_BITS-th sclkNegEdge.
- dmWe is high exactly 1 cycle after the DATA_BITS-th data sclkPosEdge, for exactly 1 cycle.
- The SCLK period must be at least 4 clk. Pulses arriving during GOT_ADDR/READ_LOAD/WRITE_COMMIT are dropped.
- sclkPosEdge and sclkNegEdge in the same cycle: each is evaluated only by the state that counts it.

## Configuration
- SPI_CTRL_TXN_COUNT_EN defined: 16-bit txnCount increments by 1 on each entry to DONE and wraps 0xFFFF -> 0x0000. Aborted frames are not counted. Reset clears it.
- Macro undefined: the txnCount port and counter are absent. All other behaviour is identical.

## Structure
- Package spi_ctrl_pkg holds: the state enum (3-bit encoding), default ADDR_BITS/DATA_BITS constants, and the counter-width function.
- One sub-module: spi_bit_counter (clear, increment enable, terminal-count compare against a runtime target).

## Test plan
- Write: CS low, shift 0x2A address + R/W=0, then data 0xA5 -> addrLatchEn one cycle after 8th posedge; dmWe single pulse one cycle after 8th data posedge; then DONE.
- Read: address 0x15 + R/W=1 -> srLoad exactly 2 cycles after 8th posedge; misoBufEn high through 8 negedges, then low; dmWe never asserted.
- Abort: CS high after 4 address bits -> IDLE next cycle; no strobe issued; the next full frame works normally.
- Reset mid-write after 5 data bits -> all outputs 0 next cycle; no dmWe; txnCount unchanged at 0.
- Extra SCLK pulses in DONE -> no output activity; CS high -> IDLE.
- With SPI_CTRL_TXN_COUNT_EN: 3 full frames -> txnCount=3. Then force the counter to 0xFFFF and complete one frame -> txnCount=0x0000.
